// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the fetch sequencer of the 9-bit core:
//   - fetch_state_t : run/done control FSM states
//   - INSTR_W       : instruction word width
//   - HALT_INSTR_DEF: default encoding of the program-ending instruction
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int unsigned INSTR_W = 9;

    localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the start/run/done protocol and the instruction-memory side signals
// of the fetch sequencer.
//   start         : start request from the testbench
//   instruction   : word at address pc from instruction memory
//   branch_taken  : branch_en & zero for the current instruction
//   branch_offset : signed word offset relative to the current pc
//   pc            : instruction memory word address
//   run/done      : core write qualifier / program finished
//   timeout       : watchdog stop indicator
// Modports: master = environment side, slave = fetch_sequencer.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned PC_W = 10
);
    logic               start;
    logic [INSTR_W-1:0] instruction;
    logic               branch_taken;
    logic [7:0]         branch_offset;
    logic [PC_W-1:0]    pc;
    logic               run;
    logic               done;
    logic               timeout;

    modport master (
        output start, instruction, branch_taken, branch_offset,
        input  pc, run, done, timeout
    );

    modport slave (
        input  start, instruction, branch_taken, branch_offset,
        output pc, run, done, timeout
    );

endinterface : fetch_sequencer_if

// File: rtl/fetch_sequencer_pc_next_calc.sv
// -----------------------------------------------------------------------------
// pc_next_calc
// Combinational next-pc adder, also usable for branch-target debug logic.
//   pc_i            : current pc
//   branch_taken_i  : take the branch this cycle
//   branch_offset_i : signed 8-bit word offset relative to pc_i
//   halt_i          : halt instruction present; pc holds (wins over branch)
//   pc_next_o       : next pc, wraps modulo 2**PC_W
// -----------------------------------------------------------------------------
module pc_next_calc #(
    parameter int unsigned PC_W = 10
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            branch_taken_i,
    input  logic [7:0]      branch_offset_i,
    input  logic            halt_i,
    output logic [PC_W-1:0] pc_next_o
);

    logic [PC_W-1:0] offset_ext_s;

    // Sign-extend the offset to pc width so the add wraps naturally.
    assign offset_ext_s = {{(PC_W-8){branch_offset_i[7]}}, branch_offset_i};

    // Select next pc: halt holds, taken branch adds offset, otherwise step by one.
    always_comb begin
        pc_next_o = pc_i;
        if (halt_i) begin
            pc_next_o = pc_i;
        end else if (branch_taken_i) begin
            pc_next_o = pc_i + offset_ext_s;
        end else begin
            pc_next_o = pc_i + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

endmodule : pc_next_calc

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter and the IDLE/ARMED/RUN/DONE control FSM of the
// 9-bit core. run gates all core register/memory writes.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : fetch_sequencer_if.slave (start, instruction, branch_taken,
//           branch_offset in; pc, run, done, timeout out)
// Optional build macro FETCH_WATCHDOG_EN: adds a RUN-cycle watchdog that
// forces DONE with timeout=1 after WDOG_CYCLES RUN cycles without HALT.
// Without it, timeout is tied low and no counter is built.
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned        PC_W        = 10,
    parameter logic [INSTR_W-1:0] HALT_INSTR  = HALT_INSTR_DEF,
    parameter int unsigned        WDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.slave  bus
);

    // Elaboration-time sanity checks on the configuration.
    if (PC_W < 8) begin : g_bad_pc_w
        $error("fetch_sequencer: PC_W must be at least 8");
    end
    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("fetch_sequencer: WDOG_CYCLES must be at least 2");
    end

    fetch_state_t    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next_s;
    logic            halt_s;

    assign halt_s = (bus.instruction == HALT_INSTR);

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_pc_next_calc (
        .pc_i            (pc_q),
        .branch_taken_i  (bus.branch_taken),
        .branch_offset_i (bus.branch_offset),
        .halt_i          (halt_s),
        .pc_next_o       (pc_next_s)
    );

`ifdef FETCH_WATCHDOG_EN
    localparam int unsigned     WDOG_W    = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              timeout_q;

    // Control FSM, program counter, watchdog counter and timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            wdog_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!bus.start) begin
                        state_q    <= RUN;
                        pc_q       <= '0;
                        wdog_cnt_q <= '0;
                    end
                end
                RUN: begin
                    // HALT outranks the watchdog expiring in the same cycle.
                    if (halt_s) begin
                        state_q <= DONE;
                    end else if (wdog_cnt_q == WDOG_LAST) begin
                        state_q   <= DONE;
                        timeout_q <= 1'b1;
                    end else begin
                        pc_q       <= pc_next_s;
                        wdog_cnt_q <= wdog_cnt_q + {{(WDOG_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state_q   <= ARMED;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.timeout = timeout_q;
`else
    // Control FSM and program counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!bus.start) begin
                        state_q <= RUN;
                        pc_q    <= '0;
                    end
                end
                RUN: begin
                    // pc_next_s already holds pc when HALT is present.
                    pc_q <= pc_next_s;
                    if (halt_s) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state_q <= ARMED;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.timeout = 1'b0;
`endif

    // Outputs decode registered state only; reset drops run asynchronously.
    assign bus.pc   = pc_q;
    assign bus.run  = (state_q == RUN);
    assign bus.done = (state_q == DONE);

endmodule : fetch_sequencer
